// File: rtl/ltc2308_emu.sv
// LTC2308 SPI-slave emulator: oversamples CONVST/SCK/SDI with clk, models the
// convert time, captures the 6-bit config word and shifts the selected code out MSB first.
module ltc2308_emu #(
  parameter int CONV_CYCLES = 52
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [95:0] ch_data,
  input  logic        ADC_CONVST,
  input  logic        ADC_SCK,
  input  logic        ADC_SDI,
  output logic        ADC_SDO,
  output logic        busy,
  output logic [5:0]  cfg_word,
  output logic        cfg_strobe,
  output logic        cfg_err,
  output logic        frame_err
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONVERT, READY, SHIFT} state_t;

  state_t           state_r;
  logic [2:0]       convst_sync_r;
  logic [2:0]       sck_sync_r;
  logic [1:0]       sdi_sync_r;
  logic [11:0]      data_sr_r;
  logic [5:0]       cfg_sr_r;
  logic [5:0]       cfg_word_r;
  logic [2:0]       cfg_cnt_r;
  logic [3:0]       dat_cnt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             sdo_r;
  logic             busy_r;
  logic             cfg_strobe_r;
  logic             cfg_err_r;
  logic             frame_err_r;

  logic             conv_rise_s;
  logic             sck_rise_s;
  logic             sck_fall_s;
  logic             sdi_s;
  logic             start_s;
  logic [2:0]       ch_sel_s;
  logic [11:0]      raw_code_s;
  logic [11:0]      start_code_s;

  function automatic logic [11:0] pick_code(input logic [95:0] d, input logic [2:0] ch);
    case (ch)
      3'd0:    pick_code = d[11:0];
      3'd1:    pick_code = d[23:12];
      3'd2:    pick_code = d[35:24];
      3'd3:    pick_code = d[47:36];
      3'd4:    pick_code = d[59:48];
      3'd5:    pick_code = d[71:60];
      3'd6:    pick_code = d[83:72];
      3'd7:    pick_code = d[95:84];
      default: pick_code = 12'h000;
    endcase
  endfunction

  // Two-flop synchronizers plus a third copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      convst_sync_r <= 3'b000;
      sck_sync_r    <= 3'b000;
      sdi_sync_r    <= 2'b00;
    end else begin
      convst_sync_r <= {convst_sync_r[1:0], ADC_CONVST};
      sck_sync_r    <= {sck_sync_r[1:0], ADC_SCK};
      sdi_sync_r    <= {sdi_sync_r[0], ADC_SDI};
    end
  end

  assign conv_rise_s = convst_sync_r[1] & ~convst_sync_r[2];
  assign sck_rise_s  = sck_sync_r[1] & ~sck_sync_r[2];
  assign sck_fall_s  = ~sck_sync_r[1] & sck_sync_r[2];
  assign sdi_s       = sdi_sync_r[1];
  // CONVST outside CONVERT always (re)starts a conversion and masks any SCK edge
  assign start_s     = conv_rise_s && (state_r != CONVERT);

  // Channel select and code transform from the currently active config
  always_comb begin
    ch_sel_s   = {cfg_word_r[3], cfg_word_r[2], cfg_word_r[4]};
    raw_code_s = pick_code(ch_data, ch_sel_s);
    if (!cfg_word_r[5]) begin
      start_code_s = 12'h000;
    end else if (!cfg_word_r[1]) begin
      start_code_s = raw_code_s ^ 12'h800;
    end else begin
      start_code_s = raw_code_s;
    end
  end

  // Protocol state machine with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      data_sr_r    <= 12'h000;
      cfg_sr_r     <= 6'b000000;
      cfg_word_r   <= 6'b100010;
      cfg_cnt_r    <= 3'd0;
      dat_cnt_r    <= 4'd0;
      cnt_r        <= {CNT_W{1'b0}};
      sdo_r        <= 1'b0;
      busy_r       <= 1'b0;
      cfg_strobe_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      cfg_strobe_r <= 1'b0;
      cfg_err_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      if (start_s) begin
        state_r   <= CONVERT;
        busy_r    <= 1'b1;
        sdo_r     <= 1'b0;
        data_sr_r <= start_code_s;
        cnt_r     <= CNT_LOAD;
        cfg_sr_r  <= 6'b000000;
        cfg_cnt_r <= 3'd0;
        dat_cnt_r <= 4'd0;
        cfg_err_r <= ~cfg_word_r[5];
      end else begin
        case (state_r)
          IDLE: begin
            sdo_r <= 1'b0;
          end
          CONVERT: begin
            if (conv_rise_s || sck_rise_s || sck_fall_s) frame_err_r <= 1'b1;
            if (cnt_r == {CNT_W{1'b0}}) begin
              state_r   <= READY;
              busy_r    <= 1'b0;
              sdo_r     <= data_sr_r[11];
              cfg_cnt_r <= 3'd0;
              dat_cnt_r <= 4'd0;
            end else begin
              cnt_r <= cnt_r - 1'b1;
            end
          end
          READY, SHIFT: begin
            if (sck_rise_s) begin
              state_r <= SHIFT;
              if (cfg_cnt_r < 3'd6) begin
                cfg_sr_r  <= {cfg_sr_r[4:0], sdi_s};
                cfg_cnt_r <= cfg_cnt_r + 3'd1;
                // The new word only takes effect at the next CONVST
                if (cfg_cnt_r == 3'd5) begin
                  cfg_word_r   <= {cfg_sr_r[4:0], sdi_s};
                  cfg_strobe_r <= 1'b1;
                end
              end
            end else if (sck_fall_s && (state_r == SHIFT)) begin
              data_sr_r <= {data_sr_r[10:0], 1'b0};
              dat_cnt_r <= dat_cnt_r + 4'd1;
              if (dat_cnt_r == 4'd11) begin
                sdo_r   <= 1'b0;
                state_r <= IDLE;
              end else begin
                sdo_r <= data_sr_r[10];
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            sdo_r   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ADC_SDO    = sdo_r;
  assign busy       = busy_r;
  assign cfg_word   = cfg_word_r;
  assign cfg_strobe = cfg_strobe_r;
  assign cfg_err    = cfg_err_r;
  assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_ltc2308_emu.sv
// Bench for ltc2308_emu: table of config-pipelined frames checked through a
// readout scoreboard, plus protocol-error, bipolar, abort and reset sequences.
module tb_ltc2308_emu;

  logic        clk;
  logic        reset_n;
  logic [95:0] ch_data;
  logic        ADC_CONVST;
  logic        ADC_SCK;
  logic        ADC_SDI;
  logic        ADC_SDO;
  logic        busy;
  logic [5:0]  cfg_word;
  logic        cfg_strobe;
  logic        cfg_err;
  logic        frame_err;

  ltc2308_emu #(.CONV_CYCLES(52)) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data),
    .ADC_CONVST(ADC_CONVST), .ADC_SCK(ADC_SCK), .ADC_SDI(ADC_SDI),
    .ADC_SDO(ADC_SDO), .busy(busy), .cfg_word(cfg_word),
    .cfg_strobe(cfg_strobe), .cfg_err(cfg_err), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_strobe = 0;
  int n_cfgerr = 0;
  int n_frerr = 0;
  logic [11:0] sb_q[$];

  typedef struct {
    logic [5:0]  cfg_in;
    logic [11:0] exp_data;
    int          exp_err;
  } vec_t;
  vec_t vecs[10];

  // Pulse counters sampled on the falling edge
  always @(negedge clk) begin
    if (cfg_strobe) n_strobe++;
    if (cfg_err) n_cfgerr++;
    if (frame_err) n_frerr++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic start_conv(input string name);
    int lat;
    lat = 0;
    ADC_CONVST = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) ADC_CONVST = 1'b0;
      if (busy) begin
        lat = k;
        break;
      end
    end
    ADC_CONVST = 1'b0;
    check({name, " busy latency"}, lat, 3);
  endtask

  // inject: 0 none, 1 CONVST pulse during CONVERT, 2 SCK pulse during CONVERT
  task automatic wait_done(input int inject, input string name);
    int n;
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (inject == 1 && n == 20) ADC_CONVST = 1'b1;
      if (inject == 1 && n == 23) ADC_CONVST = 1'b0;
      if (inject == 2 && n == 20) ADC_SCK = 1'b1;
      if (inject == 2 && n == 24) ADC_SCK = 1'b0;
    end
    check({name, " busy length"}, n, 52);
  endtask

  task automatic read_frame(input logic [5:0] cfg_in, input int nbits, output logic [11:0] word);
    word = 12'h000;
    for (int i = 0; i < nbits; i++) begin
      ADC_SDI = (i < 6) ? cfg_in[5-i] : 1'b0;
      repeat (4) @(negedge clk);
      ADC_SCK = 1'b1;
      repeat (4) @(negedge clk);
      word = {word[10:0], ADC_SDO};
      ADC_SCK = 1'b0;
    end
    ADC_SDI = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [5:0] cfg_in, input logic [11:0] exp_data,
                           input int exp_err, input int inject, input string name);
    int s0, e0, f0;
    logic [11:0] w;
    logic [11:0] exp_w;
    s0 = n_strobe;
    e0 = n_cfgerr;
    f0 = n_frerr;
    sb_q.push_back(exp_data);
    start_conv(name);
    wait_done(inject, name);
    read_frame(cfg_in, 12, w);
    if (sb_q.size() == 0) begin
      check({name, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      exp_w = sb_q.pop_front();
      check({name, " data"}, w, exp_w);
    end
    check({name, " sdo after frame"}, ADC_SDO, 1'b0);
    check({name, " cfg_word"}, cfg_word, cfg_in);
    check({name, " strobes"}, n_strobe - s0, 1);
    check({name, " cfg_err"}, n_cfgerr - e0, exp_err);
    check({name, " frame_err"}, n_frerr - f0, inject);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " sdo"}, ADC_SDO, 1'b0);
    check({name, " busy"}, busy, 1'b0);
    check({name, " cfg_word"}, cfg_word, 6'b100010);
    check({name, " pulses"}, {cfg_strobe, cfg_err, frame_err}, 3'b000);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] w;
    int s0, f0;
    vecs[0] = '{6'b110010, 12'hA5C, 0};
    vecs[1] = '{6'b100000, 12'h123, 0};
    vecs[2] = '{6'b000010, 12'h25C, 0};
    vecs[3] = '{6'b101010, 12'h000, 1};
    vecs[4] = '{6'b111110, 12'hABC, 0};
    vecs[5] = '{6'b100111, 12'hFFF, 0};
    vecs[6] = '{6'b111011, 12'h456, 0};
    vecs[7] = '{6'b100010, 12'hDEF, 0};
    vecs[8] = '{6'b110001, 12'hA5C, 0};
    vecs[9] = '{6'b100010, 12'h923, 0};

    ch_data = {12'hFFF, 12'h0F0, 12'hDEF, 12'hABC, 12'h789, 12'h456, 12'h123, 12'hA5C};
    reset_n = 1'b0;
    ADC_CONVST = 1'b0;
    ADC_SCK = 1'b0;
    ADC_SDI = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_frame(vecs[i].cfg_in, vecs[i].exp_data, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
      repeat (3) @(negedge clk);
    end

    run_frame(6'b100010, 12'hA5C, 0, 1, "convst_in_convert");
    repeat (3) @(negedge clk);
    run_frame(6'b100010, 12'hA5C, 0, 2, "sck_in_convert");
    repeat (3) @(negedge clk);

    // SCK edges in IDLE are ignored
    f0 = n_frerr;
    for (int i = 0; i < 2; i++) begin
      ADC_SCK = 1'b1;
      repeat (4) @(negedge clk);
      check("idle sck high sdo", ADC_SDO, 1'b0);
      ADC_SCK = 1'b0;
      repeat (4) @(negedge clk);
      check("idle sck low sdo", ADC_SDO, 1'b0);
    end
    check("idle sck frame_err", n_frerr - f0, 0);

    run_frame(6'b100000, 12'hA5C, 0, 0, "bipolar_cfg");
    ch_data[11:0] = 12'h000;
    run_frame(6'b100010, 12'h800, 0, 0, "bipolar_read");
    ch_data[11:0] = 12'hA5C;
    repeat (3) @(negedge clk);

    // Abort after 3 SCK bits: partial config discarded
    s0 = n_strobe;
    start_conv("abort_first");
    wait_done(0, "abort_first");
    read_frame(6'b110010, 3, w);
    check("abort partial data", w, 12'h5);
    check("abort cfg_word", cfg_word, 6'b100010);
    check("abort strobes", n_strobe - s0, 0);
    run_frame(6'b100010, 12'hA5C, 0, 0, "after_abort");
    repeat (3) @(negedge clk);

    // Reset in SHIFT after the config word was updated
    start_conv("rst_frame");
    wait_done(0, "rst_frame");
    read_frame(6'b110010, 8, w);
    check("pre-reset cfg_word", cfg_word, 6'b110010);
    ADC_SCK = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_vals("mid_shift_reset");
    ADC_SCK = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    run_frame(6'b100010, 12'hA5C, 0, 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
